gpio_irq_ctrl: RTL

Per-pin debounce, edge detection and interrupt aggregation for the GPIO port. Sits directly downstream of the GPIO core. Consumes its 2-FF-synchronised read bus and produces debounced pin levels, sticky per-pin edge status and a single level interrupt to the CPU interrupt controller. Inputs are already synchronous to clk_i, so no extra synchronisation happens here.

---
 rtl/gpio_irq_ctrl.sv | 70 +++++++
 1 files changed

// File: rtl/gpio_irq_ctrl.sv
// Per-pin debounce, edge detection and sticky status with a single level interrupt.
// The inputs are already synchronous to clk_i, so this block does no synchronisation.
module gpio_irq_ctrl #(
  parameter int WIDTH_PORT = 8,
  parameter int DB_CNT_W   = 16
) (
  input  logic                  clk_i,
  input  logic                  resetn_i,
  input  logic [WIDTH_PORT-1:0] gpi_sync_i,
  input  logic [DB_CNT_W-1:0]   db_limit_i,
  input  logic [WIDTH_PORT-1:0] rise_en_i,
  input  logic [WIDTH_PORT-1:0] fall_en_i,
  input  logic [WIDTH_PORT-1:0] irq_en_i,
  input  logic [WIDTH_PORT-1:0] clr_i,
  output logic [WIDTH_PORT-1:0] debounced_o,
  output logic [WIDTH_PORT-1:0] status_o,
  output logic                  irq_o
);

  logic [DB_CNT_W-1:0]   cnt_q [WIDTH_PORT];
  logic [DB_CNT_W-1:0]   cnt_d [WIDTH_PORT];
  logic [WIDTH_PORT-1:0] debounced_q, debounced_d;
  logic [WIDTH_PORT-1:0] status_q, status_d;
  logic [WIDTH_PORT-1:0] rise_evt, fall_evt;
  logic                  irq_q, irq_d;

  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
    debounced_d = debounced_q;
    rise_evt    = '0;
    fall_evt    = '0;
    for (int i = 0; i < WIDTH_PORT; i++) begin
      cnt_d[i] = '0;
      if (gpi_sync_i[i] != debounced_q[i]) begin
        // >= lets a lowered threshold take effect on the next edge; the count cannot pass the limit.
        if (cnt_q[i] >= db_limit_i) begin
          debounced_d[i] = gpi_sync_i[i];
          rise_evt[i]    = gpi_sync_i[i];
          fall_evt[i]    = ~gpi_sync_i[i];
        end else begin
          cnt_d[i] = cnt_q[i] + DB_CNT_W'(1);
        end
      end
    end
    // Set terms are ORed after the clear, so a same-cycle set wins.
    status_d = (status_q & ~clr_i) | (rise_evt & rise_en_i) | (fall_evt & fall_en_i);
    irq_d    = |(status_d & irq_en_i);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      // NOTE: the counter array is reset too; a stale count would shorten the first debounce after reset.
      for (int i = 0; i < WIDTH_PORT; i++) cnt_q[i] <= '0;
      debounced_q <= '0;
      status_q    <= '0;
      irq_q       <= 1'b0;
    end else begin
      for (int i = 0; i < WIDTH_PORT; i++) cnt_q[i] <= cnt_d[i];
      debounced_q <= debounced_d;
      status_q    <= status_d;
      irq_q       <= irq_d;
    end
  end

  assign debounced_o = debounced_q;
  assign status_o    = status_q;
  assign irq_o       = irq_q;

endmodule
